// File: rtl/imem_loadable.sv
// Loadable instruction memory: registered fetch address, combinational read,
// streaming load port. Optional macro IMEM_WRAP_EN wraps out-of-range fetches.
module imem_loadable #(
  parameter int          DEPTH    = 1024,
  parameter int          CNT_W    = $clog2(DEPTH) + 1,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [29:0]      addr,
  output logic [31:0]      inst,
  output logic             busy,
  input  logic             ld_start,
  input  logic [31:0]      ld_data,
  input  logic             ld_valid,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             ld_done,
  output logic             ld_ovf,
  output logic [CNT_W-1:0] ld_count
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_MAX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [29:0]   addr_r;
  logic [31:0]   mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      addr_r <= '0;
    else if (!stall)
      addr_r <= addr;
  end

  // Memory is deliberately outside the reset domain so an aborted load keeps its words.
  always_ff @(posedge clk) begin
    if (state == LOAD && ld_valid)
      mem[ptr] <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      ld_count <= '0;
      ld_ovf   <= 1'b0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            state    <= LOAD;
            ptr      <= '0;
            ld_count <= '0;
            ld_ovf   <= 1'b0;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            ptr      <= ptr + 1'b1;
            ld_count <= ld_count + 1'b1;
            if (ld_last || ptr == PTR_MAX) begin
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
              ld_ovf   <= ~ld_last;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_WRAP_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_r[29:AW];

  always_comb begin
    inst = NOP_WORD;
    if (state != LOAD)
      inst = mem[addr_r[AW-1:0]];
  end
`else
  always_comb begin
    inst = NOP_WORD;
    if (state != LOAD && addr_r[29:AW] == '0)
      inst = mem[addr_r[AW-1:0]];
  end
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable (DEPTH=16): directed load/fetch tables,
// overflow and reset-abort sequences, randomized loads and fetches against a model.
module tb_imem_loadable;

  localparam int          DEPTH = 16;
  localparam int          CNT_W = 5;
  localparam logic [31:0] NOP   = 32'h00000000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall = 1'b0;
  logic [29:0]      addr = '0;
  logic [31:0]      inst;
  logic             busy;
  logic             ld_start = 1'b0;
  logic [31:0]      ld_data = '0;
  logic             ld_valid = 1'b0;
  logic             ld_last = 1'b0;
  logic             ld_ready;
  logic             ld_done;
  logic             ld_ovf;
  logic [CNT_W-1:0] ld_count;

  imem_loadable #(.DEPTH(DEPTH), .CNT_W(CNT_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .addr(addr), .inst(inst), .busy(busy),
    .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_ovf(ld_ovf), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] a;
    logic        st;
    logic [31:0] exp;
  } fvec_t;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] stim [32];
  logic [29:0] model_ar;
  fvec_t       ftab [9];
  int          errors = 0;
  int          checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_inst(input logic [29:0] a);
    if (a < 30'(DEPTH)) return model_mem[int'(a)];
`ifdef IMEM_WRAP_EN
    return model_mem[int'(a % 30'(DEPTH))];
`else
    return NOP;
`endif
  endfunction

  // mode 0: valid every cycle, 1: alternating starting high, 2: random (with stray ld_start)
  task automatic run_load(input int n, input bit use_last, input int mode, input string tag);
    int  idx, done_pulses, bad;
    bit  was_ready, finished, toggle, v;
    int  exp_cnt;
    bit  exp_ovf;
    exp_cnt = (n < DEPTH) ? n : DEPTH;
    exp_ovf = !(use_last && n <= DEPTH);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check({tag, " ready_after_start"}, 32'(ld_ready), 32'd1);
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    idx = 0; finished = 0; done_pulses = 0; bad = 0; toggle = 1;
    for (int c = 0; c < 200 && !finished; c++) begin
      case (mode)
        0: v = 1'b1;
        1: begin v = toggle; toggle = !toggle; end
        default: v = 1'($urandom % 2);
      endcase
      if (idx >= n) v = 1'b0;
      ld_valid = v;
      ld_data  = v ? stim[idx] : $urandom;
      ld_last  = use_last && (idx == n - 1);
      if (mode == 2) ld_start = ($urandom % 4 == 0);
      if (ld_ready && inst !== NOP) bad++;
      if (ld_ready && busy !== 1'b1) bad++;
      was_ready = ld_ready;
      tick();
      if (v && was_ready) idx++;
      if (ld_done) begin done_pulses++; finished = 1; end
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
    check({tag, " done_seen"}, 32'(finished), 32'd1);
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
    check({tag, " ready_in_done"}, 32'(ld_ready), 32'd0);
    check({tag, " ld_count"}, 32'(ld_count), 32'(exp_cnt));
    check({tag, " ld_ovf"}, 32'(ld_ovf), 32'(exp_ovf));
    tick();
    if (ld_done) done_pulses++;
    check({tag, " done_pulses"}, 32'(done_pulses), 32'd1);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
    check({tag, " count_hold"}, 32'(ld_count), 32'(exp_cnt));
    check({tag, " nop_busy_in_load"}, 32'(bad), 32'd0);
    for (int i = 0; i < exp_cnt; i++) model_mem[i] = stim[i];
  endtask

  task automatic fetch(input logic [29:0] a, input logic st, input logic [31:0] exp, input string name);
    addr = a; stall = st;
    tick();
    check(name, inst, exp);
  endtask

  initial begin
    ftab[0] = '{30'd0,  1'b0, 32'h3c1d1000};
    ftab[1] = '{30'd1,  1'b0, 32'h0c000003};
    ftab[2] = '{30'd2,  1'b0, 32'h37bd1000};
    ftab[3] = '{30'd1,  1'b0, 32'h0c000003};
    ftab[4] = '{30'd2,  1'b1, 32'h0c000003};
    ftab[5] = '{30'd3,  1'b1, 32'h0c000003};
    ftab[6] = '{30'd2,  1'b0, 32'h37bd1000};
`ifdef IMEM_WRAP_EN
    ftab[7] = '{30'd17, 1'b0, 32'h0c000003};
    ftab[8] = '{30'd18, 1'b0, 32'h37bd1000};
`else
    ftab[7] = '{30'd17, 1'b0, NOP};
    ftab[8] = '{30'd18, 1'b0, NOP};
`endif

    #2;
    check("rst busy", 32'(busy), 32'd0);
    check("rst ld_ready", 32'(ld_ready), 32'd0);
    check("rst ld_done", 32'(ld_done), 32'd0);
    check("rst ld_ovf", 32'(ld_ovf), 32'd0);
    check("rst ld_count", 32'(ld_count), 32'd0);
    #10;
    rst = 1'b0;
    tick();

    stim[0] = 32'h3c1d1000; stim[1] = 32'h0c000003; stim[2] = 32'h37bd1000;
    run_load(3, 1'b1, 0, "load3");
    for (int i = 0; i < 9; i++)
      fetch(ftab[i].a, ftab[i].st, ftab[i].exp, $sformatf("fetch_tab[%0d]", i));

    stim[0] = 32'haaaa0001; stim[1] = 32'haaaa0002; stim[2] = 32'haaaa0003;
    run_load(3, 1'b1, 1, "gaps");
    for (int i = 0; i < 3; i++)
      fetch(30'(i), 1'b0, model_mem[i], $sformatf("gaps_fetch[%0d]", i));

    for (int i = 0; i < 20; i++) stim[i] = 32'h5000_0000 + 32'(i * 17);
    run_load(20, 1'b0, 0, "ovf");
    fetch(30'd15, 1'b0, 32'h5000_0000 + 32'(15 * 17), "ovf mem15");

    for (int r = 0; r < 3; r++) begin
      int  n;
      bit  ul;
      n = $urandom_range(1, 20);
      ul = (n < DEPTH) ? 1'b1 : ((n == DEPTH) ? 1'($urandom % 2) : 1'b0);
      for (int i = 0; i < 20; i++) stim[i] = $urandom;
      run_load(n, ul, 2, $sformatf("rand_load%0d", r));
      for (int c = 0; c < 40; c++) begin
        logic [29:0] a;
        logic        s;
        a = 30'($urandom_range(0, 31));
        s = (c == 0) ? 1'b0 : 1'($urandom % 3 == 0);
        ld_valid = 1'($urandom % 2);
        ld_data  = $urandom;
        addr = a; stall = s;
        tick();
        if (!s) model_ar = a;
        check($sformatf("rand_fetch[%0d.%0d]", r, c), inst, ref_inst(model_ar));
      end
      ld_valid = 1'b0;
      stall = 1'b0;
    end

    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stim[i] = 32'hc0de_0000 + 32'(i);
      ld_valid = 1'b1;
      ld_data  = stim[i];
      tick();
    end
    ld_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) model_mem[i] = stim[i];
    check("abort busy", 32'(busy), 32'd0);
    check("abort ld_ready", 32'(ld_ready), 32'd0);
    check("abort ld_count", 32'(ld_count), 32'd0);
    check("abort ld_ovf", 32'(ld_ovf), 32'd0);
    check("abort inst", inst, model_mem[0]);
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      fetch(30'(i), 1'b0, model_mem[i], $sformatf("abort_fetch[%0d]", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
